// File: rtl/pipe_arith_pkg.sv
// Shared constants and the inter-stage record for the pipelined
// 64-bit add/subtract datapath.
package pipe_arith_pkg;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int STAGES = WIDTH / SLICE;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             zero_acc;
    logic             op_sub;
    logic             a_sgn;
    logic             b_sgn;
    logic             ovf;
  } stage_t;

endpackage

// File: rtl/pipe_sub_64bit_if.sv
// Operand/result streaming bundle for pipe_sub_64bit.
// The block plays the slave side; the producer/consumer plays master.
interface pipe_sub_64bit_if;
  import pipe_arith_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result,
    output carry, borrow, ovf, zero
  );

  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result,
    input  carry, borrow, ovf, zero
  );

endinterface

// File: rtl/pipe_sub_slice16.sv
// Combinational 16-bit carry-look-ahead slice with optional
// operand inversion for subtraction (4-bit groups, two-level).
module pipe_sub_slice16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  input  logic        i_op_sub,
  output logic [15:0] o_sum,
  output logic        o_cout,
  output logic        o_zero
);

  logic [15:0] w_bb;
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  always_comb begin
    w_bb = i_b ^ {16{i_op_sub}};
    w_g  = i_a & w_bb;
    w_p  = i_a ^ w_bb;
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    for (int n = 0; n < 4; n++) begin
      w_gg[n] = w_g[4*n];
      for (int j = 1; j < 4; j++)
        w_gg[n] = w_g[4*n+j] | (w_p[4*n+j] & w_gg[n]);
      w_gp[n] = &w_p[4*n +: 4];
    end
    w_gc[0] = i_cin;
    for (int n = 0; n < 4; n++)
      w_gc[n+1] = w_gg[n] | (w_gp[n] & w_gc[n]);
    // group carries seed each nibble; bits inside a nibble ripple locally
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0)
        w_c[i] = w_gc[i/4];
      else
        w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[4];
  assign o_zero = ~|o_sum;

endmodule

// File: rtl/pipe_sub_64bit.sv
// Four-stage pipelined 64-bit add/subtract, one 16-bit slice per
// stage, with a global valid/ready stall and registered flags.
module pipe_sub_64bit
  import pipe_arith_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pipe_sub_64bit_if.slave bus
);

  logic   w_adv;
  stage_t w_in;
  stage_t w_last;

  always_comb begin
    w_in          = '0;
    w_in.valid    = bus.in_valid;
    w_in.a        = bus.a;
    w_in.b        = bus.b;
    w_in.op_sub   = bus.op_sub;
    w_in.c        = bus.op_sub;
    w_in.zero_acc = 1'b1;
    w_in.a_sgn    = bus.a[WIDTH-1];
    w_in.b_sgn    = bus.b[WIDTH-1] ^ bus.op_sub;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t           w_src;
    stage_t           w_nxt;
    stage_t           r_q;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_zero;

    if (k == 0) begin : g_first
      assign w_src = w_in;
    end else begin : g_next
      assign w_src = g_st[k-1].r_q;
    end

    pipe_sub_slice16 u_slice (
      .i_a      (w_src.a[k*SLICE +: SLICE]),
      .i_b      (w_src.b[k*SLICE +: SLICE]),
      .i_cin    (w_src.c),
      .i_op_sub (w_src.op_sub),
      .o_sum    (w_sum),
      .o_cout   (w_cout),
      .o_zero   (w_zero)
    );

    always_comb begin
      w_nxt = w_src;
      w_nxt.res[k*SLICE +: SLICE] = w_sum;
      w_nxt.c        = w_cout;
      w_nxt.zero_acc = w_src.zero_acc & w_zero;
      if (k == STAGES-1)
        w_nxt.ovf = (w_src.a_sgn == w_src.b_sgn) &
                    (w_sum[SLICE-1] != w_src.a_sgn);
    end

    always_ff @(posedge clk) begin
      if (rst)
        r_q.valid <= 1'b0;
      else if (w_adv)
        r_q <= w_nxt;
    end
  end

  assign w_last = g_st[STAGES-1].r_q;
  assign w_adv  = ~w_last.valid | bus.out_ready;

  // data flops are unreset, so everything is gated by the last valid
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = w_last.valid;
  assign bus.result    = w_last.valid ? w_last.res : '0;
  assign bus.carry     = w_last.valid & w_last.c;
  assign bus.borrow    = w_last.valid & w_last.op_sub & ~w_last.c;
  assign bus.ovf       = w_last.valid & w_last.ovf;
  assign bus.zero      = w_last.valid & w_last.zero_acc;

endmodule
